// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// Protocol: a requester holds req[k] high for as long as it wants the resource.
// grant[k] (registered) tells it that it owns the resource. It keeps ownership
// until it pulses done, drops req[k], or the arbiter revokes the grant (preempt).
// grant_valid == |grant in every cycle. The dbg_* lines expose internal state
// for observation only.
interface rr_arbiter_4_if;
  logic [0:3] req;
  logic       done;
  logic [0:3] grant;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic       preempt;
  logic       dbg_state;     // 0 = IDLE, 1 = BUSY
  logic [1:0] dbg_ptr;
  logic [7:0] dbg_hold_cnt;

  modport master (
    output req, done,
    input  grant, grant_valid, grant_idx, preempt,
    input  dbg_state, dbg_ptr, dbg_hold_cnt
  );

  modport slave (
    input  req, done,
    output grant, grant_valid, grant_idx, preempt,
    output dbg_state, dbg_ptr, dbg_hold_cnt
  );
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a hold limit. It produces a registered
// one-hot (or all-zero) grant vector. Every handover passes through IDLE, so
// there is always at least one all-zero cycle between two grants.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 16   // 0 disables the limit, legal 0..255
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_4_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     r_state, w_state_nxt;
  logic [0:3] r_grant, w_grant_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [7:0] r_hold_cnt, w_hold_nxt;
  logic       r_preempt, w_preempt_nxt;
  logic       r_valid;

  logic       w_found;
  logic [1:0] w_pick;
  logic [1:0] w_cand;
  logic       w_limit;
  logic       w_withdrawn;
  logic       w_release;

  // Pick the first active requester, starting from the priority pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_cand  = r_ptr;
    for (int i = 0; i < 4; i++) begin
      w_cand = r_ptr + 2'(i);
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Release conditions for the current grantee.
  always_comb begin
    w_limit     = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LIM);
    w_withdrawn = !bus.req[r_idx];
    w_release   = bus.done || w_withdrawn || w_limit;
  end

  // Next-state and next-output logic. All outputs are registered from these values.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_idx_nxt     = r_idx;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold_cnt;
    w_preempt_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt         = ST_BUSY;
          w_grant_nxt         = '0;
          w_grant_nxt[w_pick] = 1'b1;
          w_idx_nxt           = w_pick;
          w_hold_nxt          = 8'd1;
        end
      end
      ST_BUSY: begin
        if (w_release) begin
          w_state_nxt   = ST_IDLE;
          w_grant_nxt   = '0;
          w_idx_nxt     = 2'd0;
          w_ptr_nxt     = r_idx + 2'd1;
          w_hold_nxt    = 8'd0;
          // preempt flags only a revocation that the grantee did not ask for
          w_preempt_nxt = w_limit && !bus.done && !w_withdrawn;
        end else if (r_hold_cnt != 8'hFF) begin
          w_hold_nxt = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_idx_nxt   = 2'd0;
        w_hold_nxt  = 8'd0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_valid    <= 1'b0;
      r_idx      <= 2'd0;
      r_ptr      <= 2'd0;
      r_hold_cnt <= 8'd0;
      r_preempt  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_valid    <= |w_grant_nxt;
      r_idx      <= w_idx_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_preempt  <= w_preempt_nxt;
    end
  end

  assign bus.grant        = r_grant;
  assign bus.grant_valid  = r_valid;
  assign bus.grant_idx    = r_idx;
  assign bus.preempt      = r_preempt;
  assign bus.dbg_state    = r_state;
  assign bus.dbg_ptr      = r_ptr;
  assign bus.dbg_hold_cnt = r_hold_cnt;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Testbench for rr_arbiter_4: one instance with MAX_HOLD=4 and one with the
// limit disabled. The driver pushes the expected post-edge outputs into a queue.
// A monitor pops the queue and compares one cycle later.
module tb_rr_arbiter_4;

  localparam int W = 10;  // {grant[4], grant_valid, grant_idx[2], preempt, ptr[2]}

  logic clk;
  logic rst_n;

  rr_arbiter_4_if bus4 ();
  rr_arbiter_4_if bus0 ();

  rr_arbiter_4 #(.MAX_HOLD(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  rr_arbiter_4 #(.MAX_HOLD(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  logic [W-1:0] exp4_q[$];
  logic [W-1:0] exp0_q[$];
  int n_checks;
  int n_errors;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scalar checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step4(input logic [0:3] req, input logic done, input logic [0:3] g,
                       input logic [1:0] idx, input logic pre, input logic [1:0] ptr);
    @(negedge clk);
    bus4.req  = req;
    bus4.done = done;
    exp4_q.push_back({g, (g != 4'b0000), idx, pre, ptr});
  endtask

  task automatic step0(input logic [0:3] req, input logic done, input logic [0:3] g,
                       input logic [1:0] idx, input logic pre, input logic [1:0] ptr);
    @(negedge clk);
    bus0.req  = req;
    bus0.done = done;
    exp0_q.push_back({g, (g != 4'b0000), idx, pre, ptr});
  endtask

  // Assert reset between edges, check the immediate effect, release a cycle later.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({tag, "_grant"},   32'(bus4.grant), 32'h0);
    check({tag, "_gvalid"},  32'(bus4.grant_valid), 32'h0);
    check({tag, "_idx"},     32'(bus4.grant_idx), 32'h0);
    check({tag, "_preempt"}, 32'(bus4.preempt), 32'h0);
    check({tag, "_state"},   32'(bus4.dbg_state), 32'h0);
    check({tag, "_ptr"},     32'(bus4.dbg_ptr), 32'h0);
    check({tag, "_grant0"},  32'(bus0.grant), 32'h0);
    bus4.req  = 4'b0000;
    bus4.done = 1'b0;
    bus0.req  = 4'b0000;
    bus0.done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (exp4_q.size() > 0) begin
        e = exp4_q.pop_front();
        a = {bus4.grant, bus4.grant_valid, bus4.grant_idx, bus4.preempt, bus4.dbg_ptr};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL dut4_cycle t=%0t got grant=%b gv=%b idx=%0d pre=%b ptr=%0d expected grant=%b gv=%b idx=%0d pre=%b ptr=%0d",
                   $time, a[9:6], a[5], a[4:3], a[2], a[1:0], e[9:6], e[5], e[4:3], e[2], e[1:0]);
        end
      end
      if (exp0_q.size() > 0) begin
        e = exp0_q.pop_front();
        a = {bus0.grant, bus0.grant_valid, bus0.grant_idx, bus0.preempt, bus0.dbg_ptr};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL dut0_cycle t=%0t got grant=%b gv=%b idx=%0d pre=%b ptr=%0d expected grant=%b gv=%b idx=%0d pre=%b ptr=%0d",
                   $time, a[9:6], a[5], a[4:3], a[2], a[1:0], e[9:6], e[5], e[4:3], e[2], e[1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [0:3] g;
    logic [1:0] kk;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    bus4.req  = 4'b0000;
    bus4.done = 1'b0;
    bus0.req  = 4'b0000;
    bus0.done = 1'b0;
    repeat (3) @(negedge clk);
    check("por_grant",    32'(bus4.grant), 32'h0);
    check("por_gvalid",   32'(bus4.grant_valid), 32'h0);
    check("por_hold_cnt", 32'(bus4.dbg_hold_cnt), 32'h0);
    rst_n = 1'b1;

    // Reset mid-grant: requester 1 holds the grant when reset hits.
    step4(4'b0100, 1'b0, 4'b0100, 2'd1, 1'b0, 2'd0);
    step4(4'b0100, 1'b0, 4'b0100, 2'd1, 1'b0, 2'd0);
    do_reset("rst_mid");
    step4(4'b1111, 1'b0, 4'b1000, 2'd0, 1'b0, 2'd0);
    step4(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd1);

    // Single requester 2, done on its third BUSY cycle.
    step4(4'b0010, 1'b0, 4'b0010, 2'd2, 1'b0, 2'd1);
    step4(4'b0010, 1'b0, 4'b0010, 2'd2, 1'b0, 2'd1);
    step4(4'b0010, 1'b0, 4'b0010, 2'd2, 1'b0, 2'd1);
    step4(4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd3);
    step4(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd3);

    // Fair rotation from ptr=0, all requesting, done every second BUSY cycle.
    do_reset("rst_rot");
    for (int k = 0; k < 5; k++) begin
      kk = 2'(k % 4);
      g  = 4'b1000 >> kk;
      step4(4'b1111, 1'b0, g, kk, 1'b0, kk);
      step4(4'b1111, 1'b0, g, kk, 1'b0, kk);
      step4(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, kk + 2'd1);
    end

    // Hold limit of 4 with requester 0 alone; ptr is 1 here.
    step4(4'b1000, 1'b0, 4'b1000, 2'd0, 1'b0, 2'd1);
    step4(4'b1000, 1'b0, 4'b1000, 2'd0, 1'b0, 2'd1);
    step4(4'b1000, 1'b0, 4'b1000, 2'd0, 1'b0, 2'd1);
    step4(4'b1000, 1'b0, 4'b1000, 2'd0, 1'b0, 2'd1);
    step4(4'b1000, 1'b0, 4'b0000, 2'd0, 1'b1, 2'd1);
    step4(4'b1000, 1'b0, 4'b1000, 2'd0, 1'b0, 2'd1);
    step4(4'b1000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd1);

    // Withdrawal, done and limit on one edge; requester 3 arrives during BUSY.
    step4(4'b0100, 1'b0, 4'b0100, 2'd1, 1'b0, 2'd1);
    step4(4'b0101, 1'b0, 4'b0100, 2'd1, 1'b0, 2'd1);
    step4(4'b0101, 1'b0, 4'b0100, 2'd1, 1'b0, 2'd1);
    step4(4'b0101, 1'b0, 4'b0100, 2'd1, 1'b0, 2'd1);
    step4(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd2);
    step4(4'b0001, 1'b0, 4'b0001, 2'd3, 1'b0, 2'd2);
    step4(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0);

    // Withdrawal alone releases without preempt.
    step4(4'b0010, 1'b0, 4'b0010, 2'd2, 1'b0, 2'd0);
    step4(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd3);

    // Limit disabled: requester 1 holds for 300 cycles, hold_cnt saturates.
    for (int k = 0; k < 300; k++) begin
      step0(4'b0100, 1'b0, 4'b0100, 2'd1, 1'b0, 2'd0);
    end
    @(posedge clk);
    #2;
    check("nolimit_hold_sat", 32'(bus0.dbg_hold_cnt), 32'd255);
    check("nolimit_state",    32'(bus0.dbg_state), 32'd1);
    step0(4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd2);

    repeat (3) @(negedge clk);
    check("queues_drained", 32'(exp4_q.size() + exp0_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
